// File: rtl/result_merge_2_to_1.sv
// Two-input result merger: a 2-deep FIFO per path feeding one output
// register, round-robin arbitrated, with a source tag on every word.
module result_merge_2_to_1 #(
  parameter int   DATA_WIDTH   = 32,
  parameter logic FULLY_CONVOL = 1'b0,
  parameter logic POOLING      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  conv_valid,
  input  logic [DATA_WIDTH-1:0] conv_data,
  output logic                  conv_ready,
  input  logic                  pool_valid,
  input  logic [DATA_WIDTH-1:0] pool_data,
  output logic                  pool_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_src,
  input  logic                  out_ready
);

  // Path index 0 is the conv path, 1 is the pool path.
  logic [DATA_WIDTH-1:0] mem_q [2][2];
  logic [DATA_WIDTH-1:0] mem_d [2][2];
  logic [1:0]            cnt_q [2];
  logic [1:0]            cnt_d [2];
  logic [1:0]            rd_q, rd_d;
  logic [1:0]            wr_q, wr_d;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_src_q, out_src_d;
  logic                  last_grant_q, last_grant_d;

  logic                  in_valid [2];
  logic [DATA_WIDTH-1:0] in_data  [2];
  logic [1:0]            push;
  logic [1:0]            pop;
  logic                  free;
  logic                  gnt_pool;
  logic                  any_ne;

  assign in_valid[0] = conv_valid;
  assign in_valid[1] = pool_valid;
  assign in_data[0]  = conv_data;
  assign in_data[1]  = pool_data;

  // Ready depends only on stored counts, never on out_ready.
  assign conv_ready = (cnt_q[0] < 2'd2);
  assign pool_ready = (cnt_q[1] < 2'd2);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  // Arbitration, FIFO bookkeeping and output-register next state.
  always_comb begin
    mem_d        = mem_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;

    free     = !out_valid_q || out_ready;
    any_ne   = (cnt_q[0] != 2'd0) || (cnt_q[1] != 2'd0);
    gnt_pool = (cnt_q[1] != 2'd0) &&
               ((cnt_q[0] == 2'd0) ||
                (last_grant_q == FULLY_CONVOL));

    pop[0] = free && (cnt_q[0] != 2'd0) && !gnt_pool;
    pop[1] = free && gnt_pool;

    for (int p = 0; p < 2; p++) begin
      push[p] = in_valid[p] && (cnt_q[p] < 2'd2);
      if (push[p]) begin
        mem_d[p][wr_q[p]] = in_data[p];
        wr_d[p]           = ~wr_q[p];
      end
      if (pop[p]) begin
        rd_d[p] = ~rd_q[p];
      end
      cnt_d[p] = cnt_q[p] + 2'(push[p]) - 2'(pop[p]);
    end

    if (free) begin
      if (any_ne) begin
        out_valid_d = 1'b1;
        if (gnt_pool) begin
          out_data_d   = mem_q[1][rd_q[1]];
          out_src_d    = POOLING;
          last_grant_d = POOLING;
        end else begin
          out_data_d   = mem_q[0][rd_q[0]];
          out_src_d    = FULLY_CONVOL;
          last_grant_d = FULLY_CONVOL;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset discards all buffered and in-flight words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        mem_q[p][0] <= '0;
        mem_q[p][1] <= '0;
        cnt_q[p]    <= 2'd0;
      end
      rd_q         <= 2'b00;
      wr_q         <= 2'b00;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= FULLY_CONVOL;
      last_grant_q <= POOLING;
    end else begin
      mem_q        <= mem_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_result_merge_2_to_1.sv
// Bench for result_merge_2_to_1: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_result_merge_2_to_1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        conv_valid = 1'b0;
  logic [31:0] conv_data = '0;
  logic        conv_ready;
  logic        pool_valid = 1'b0;
  logic [31:0] pool_data = '0;
  logic        pool_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_src;
  logic        out_ready = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  result_merge_2_to_1 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .conv_valid (conv_valid),
    .conv_data  (conv_data),
    .conv_ready (conv_ready),
    .pool_valid (pool_valid),
    .pool_data  (pool_data),
    .pool_ready (pool_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: per-source queues, one output slot,
  // round-robin preference remembered as the last granted source.
  logic [31:0] cq[$];
  logic [31:0] pq[$];
  bit          m_ov;
  logic [31:0] m_data;
  bit          m_src;
  bit          m_last;
  bit          m_free, m_pc, m_pp;
  int          m_g;

  task automatic model_step();
    if (!rst_n) begin
      cq.delete();
      pq.delete();
      m_ov = 0; m_data = '0; m_src = 0; m_last = 1;
    end else begin
      m_free = !m_ov || out_ready;
      m_pc = conv_valid && (cq.size() < 2);
      m_pp = pool_valid && (pq.size() < 2);
      if (m_free) begin
        m_g = -1;
        if (cq.size() > 0 && pq.size() > 0)
          m_g = m_last ? 0 : 1;
        else if (cq.size() > 0) m_g = 0;
        else if (pq.size() > 0) m_g = 1;
        if (m_g == 0) begin
          m_data = cq.pop_front();
          m_ov = 1; m_src = 0; m_last = 0;
        end else if (m_g == 1) begin
          m_data = pq.pop_front();
          m_ov = 1; m_src = 1; m_last = 1;
        end else begin
          m_ov = 0;
        end
      end
      if (m_pc) cq.push_back(conv_data);
      if (m_pp) pq.push_back(pool_data);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("m_conv_ready", 32'(conv_ready),
        32'(cq.size() < 2));
    chk("m_pool_ready", 32'(pool_ready),
        32'(pq.size() < 2));
    chk("m_out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("m_out_data", out_data, m_data);
      chk("m_out_src", 32'(out_src), 32'(m_src));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    conv_valid = 1'b0;
    pool_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_out(string nm, logic v,
                         logic [31:0] d, logic s);
    chk({nm, "_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      chk({nm, "_data"}, out_data, d);
      chk({nm, "_src"}, 32'(out_src), 32'(s));
    end
  endtask

  int  cseq, pseq;
  int  nxt[2];
  bit  acc_c, acc_p;
  bit  prev_src;
  logic [31:0] seqw;

  initial begin
    // Reset state
    do_reset();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_conv_ready", 32'(conv_ready), 32'h1);
    chk("rst_pool_ready", 32'(pool_ready), 32'h1);

    // Single word latency
    conv_valid = 1'b1;
    conv_data = 32'h0000_00A5;
    tick();
    conv_valid = 1'b0;
    chk_out("single_k", 1'b0, 32'h0, 1'b0);
    tick();
    chk_out("single_k1", 1'b1, 32'h0000_00A5, 1'b0);
    tick();
    chk_out("single_k2", 1'b0, 32'h0, 1'b0);

    // Contention after reset: conv first, then alternate
    do_reset();
    conv_valid = 1'b1; conv_data = 32'hC0;
    pool_valid = 1'b1; pool_data = 32'hB0;
    tick();
    conv_data = 32'hC1;
    pool_data = 32'hB1;
    tick();
    conv_valid = 1'b0;
    pool_valid = 1'b0;
    chk_out("cont0", 1'b1, 32'hC0, 1'b0);
    tick();
    chk_out("cont1", 1'b1, 32'hB0, 1'b1);
    tick();
    chk_out("cont2", 1'b1, 32'hC1, 1'b0);
    tick();
    chk_out("cont3", 1'b1, 32'hB1, 1'b1);
    tick();
    chk_out("cont4", 1'b0, 32'h0, 1'b0);

    // Backpressure: 2 in FIFO plus 1 held in output
    do_reset();
    out_ready = 1'b0;
    conv_valid = 1'b1; conv_data = 32'hD0;
    tick();
    conv_data = 32'hD1;
    tick();
    conv_data = 32'hD2;
    tick();
    conv_valid = 1'b0;
    chk("bp_ready_low", 32'(conv_ready), 32'h0);
    chk_out("bp_hold0", 1'b1, 32'hD0, 1'b0);
    tick();
    chk_out("bp_hold1", 1'b1, 32'hD0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_out("bp_out1", 1'b1, 32'hD1, 1'b0);
    tick();
    chk_out("bp_out2", 1'b1, 32'hD2, 1'b0);
    tick();
    chk_out("bp_empty", 1'b0, 32'h0, 1'b0);

    // Full FIFO: a pop in the same cycle does not open a slot
    do_reset();
    out_ready = 1'b0;
    conv_valid = 1'b1; conv_data = 32'hE0;
    tick();
    conv_data = 32'hE1;
    tick();
    conv_data = 32'hE2;
    tick();
    conv_data = 32'hE3;
    out_ready = 1'b1;
    chk("full_ready0", 32'(conv_ready), 32'h0);
    tick();
    chk("full_ready1", 32'(conv_ready), 32'h1);
    chk_out("full_o1", 1'b1, 32'hE1, 1'b0);
    tick();
    conv_valid = 1'b0;
    chk_out("full_o2", 1'b1, 32'hE2, 1'b0);
    tick();
    chk_out("full_o3", 1'b1, 32'hE3, 1'b0);
    tick();
    chk_out("full_o4", 1'b0, 32'h0, 1'b0);

    // Reset mid-stream discards buffered words
    do_reset();
    out_ready = 1'b0;
    pool_valid = 1'b1; pool_data = 32'hF0;
    tick();
    pool_data = 32'hF1;
    tick();
    pool_data = 32'hF2;
    tick();
    pool_valid = 1'b0;
    chk("mid_pool_full", 32'(pool_ready), 32'h0);
    chk_out("mid_before", 1'b1, 32'hF0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_cready", 32'(conv_ready), 32'h1);
    chk("mid_rst_pready", 32'(pool_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    conv_valid = 1'b1; conv_data = 32'h0000_0C11;
    tick();
    conv_valid = 1'b0;
    tick();
    chk_out("mid_first", 1'b1, 32'h0000_0C11, 1'b0);
    tick();
    chk_out("mid_after", 1'b0, 32'h0, 1'b0);
    tick();
    chk_out("mid_after2", 1'b0, 32'h0, 1'b0);

    // Streaming: both paths always valid
    do_reset();
    cseq = 0; pseq = 0;
    nxt[0] = 0; nxt[1] = 0;
    prev_src = 1'b1;
    conv_valid = 1'b1;
    pool_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      conv_data = 32'hC000_0000 | 32'(cseq);
      pool_data = 32'hB000_0000 | 32'(pseq);
      acc_c = conv_ready;
      acc_p = pool_ready;
      tick();
      if (acc_c) cseq++;
      if (acc_p) pseq++;
      if (i >= 1) begin
        chk("st_valid", 32'(out_valid), 32'h1);
        chk("st_alt", 32'(out_src), 32'(!prev_src));
        prev_src = out_src;
        seqw = {16'h0, out_data[15:0]};
        chk("st_seq", seqw, 32'(nxt[out_src]));
        nxt[out_src] = nxt[out_src] + 1;
      end
    end
    conv_valid = 1'b0;
    pool_valid = 1'b0;
    repeat (6) tick();
    chk_out("st_drained", 1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
